// File: rtl/ps2_key_receiver.sv
// Receive-only PS/2 keyboard front end: line conditioning, 11-bit frame
// deframing and E0/F0 prefix folding into an 11-bit key event word.
module ps2_key_receiver #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_valid,
   output logic        frame_err
);

   // state  | meaning
   // IDLE   | waiting for a start bit
   // DATA   | shifting in 8 data bits, LSB first
   // PARITY | capturing the odd-parity bit
   // STOP   | checking stop bit and parity, then back to IDLE
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int TO_W   = $clog2(TO_CYC);

   logic [1:0]            clk_sync, data_sync;
   logic [FILTER_LEN-1:0] clk_hist, data_hist;
   logic                  clk_f, data_f, clk_f_q;
   logic                  fall;

   state_t       state;
   logic [2:0]   bitcnt;
   logic [7:0]   shreg;
   logic         par;
   logic         ext, rel;
   logic         frame_ok;
   logic [TO_W-1:0] to_cnt;

   // Synchronisers and filters reset to the idle (pulled-up) level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_hist  <= '1;
         data_hist <= '1;
         clk_f     <= 1'b1;
         data_f    <= 1'b1;
         clk_f_q   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
         data_hist <= {data_hist[FILTER_LEN-2:0], data_sync[1]};
         if (&clk_hist)       clk_f <= 1'b1;
         else if (~|clk_hist) clk_f <= 1'b0;
         if (&data_hist)       data_f <= 1'b1;
         else if (~|data_hist) data_f <= 1'b0;
         clk_f_q   <= clk_f;
      end
   end

   assign fall = clk_f_q & ~clk_f;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bitcnt    <= 3'd0;
         shreg     <= 8'h00;
         par       <= 1'b0;
         ext       <= 1'b0;
         rel       <= 1'b0;
         frame_ok  <= 1'b0;
         to_cnt    <= '0;
         ps2_key   <= 11'h000;
         key_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         frame_ok  <= 1'b0;

         // Decode the frame accepted on the previous cycle.
         if (frame_ok) begin
            if (shreg == 8'hE0) begin
               ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
               rel <= 1'b1;
            end else begin
               ps2_key   <= {~ps2_key[10], ~rel, ext, shreg};
               key_valid <= 1'b1;
               ext       <= 1'b0;
               rel       <= 1'b0;
            end
         end

         // A fall always takes priority over a coincident timeout.
         if (fall) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!data_f) begin
                     state  <= DATA;
                     bitcnt <= 3'd0;
                  end else begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end
               end
               DATA: begin
                  shreg  <= {data_f, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= data_f;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (data_f && (^{shreg, par})) begin
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (to_cnt == TO_W'(TO_CYC - 1)) begin
               state     <= IDLE;
               to_cnt    <= '0;
               frame_err <= 1'b1;
               ext       <= 1'b0;
               rel       <= 1'b0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: stimulus pushes expected events,
// a monitor pops and compares whenever key_valid or frame_err fires.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

   localparam int CLK_PER = 40;     // 25 MHz
   localparam int HALF    = 4000;   // PS/2 clock half period, ns

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        key_valid;
   logic        frame_err;

   ps2_key_receiver dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   always #(CLK_PER/2) clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [10:0] key;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passed = 0;
   logic        m_tog = 1'b0, m_ext = 1'b0, m_rel = 1'b0;
   logic [10:0] last_key = 11'h000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   task automatic push_code(input logic [7:0] code);
      exp_t e;
      if (code == 8'hE0) m_ext = 1'b1;
      else if (code == 8'hF0) m_rel = 1'b1;
      else begin
         m_tog    = ~m_tog;
         e.err    = 1'b0;
         e.key    = {m_tog, ~m_rel, m_ext, code};
         last_key = e.key;
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic push_err();
      exp_t e;
      e.err = 1'b1;
      e.key = last_key;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
   endtask

   // Drives the first nfalls bits of a frame (start, 8 data, parity, stop).
   task automatic send_bits(input logic [7:0] code, input logic bad_par, input int nfalls);
      logic [10:0] b;
      b = {1'b1, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nfalls; i++) begin
         ps2_data = b[i];
         #(HALF);
         ps2_clk = 1'b0;
         #(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      #(HALF);
   endtask

   task automatic send_key(input logic [7:0] code);
      push_code(code);
      send_bits(code, 1'b0, 11);
      #(3*HALF);
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (key_valid && frame_err) chk("err_and_valid_together", 1, 0);
      if (key_valid || frame_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {20'h0, frame_err, ps2_key}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("event_kind_err", {31'h0, frame_err}, {31'h0, e.err});
            if (!e.err) chk("event_key", {21'h0, ps2_key}, {21'h0, e.key});
         end
      end
   end

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      chk("reset_key", {21'h0, ps2_key}, 32'h0);
      chk("reset_valid", {31'h0, key_valid}, 32'h0);
      chk("reset_err", {31'h0, frame_err}, 32'h0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // T1: 1C press -> 61C
      send_key(8'h1C);
      chk("t1_key_hold", {21'h0, ps2_key}, 32'h61C);
      // T2: F0 1C release
      send_key(8'hF0);
      send_key(8'h1C);
      chk("t2_key_hold", {21'h0, ps2_key}, 32'h01C);
      // T3: extended press then extended release
      send_key(8'hE0);
      send_key(8'h75);
      send_key(8'hE0);
      send_key(8'hF0);
      send_key(8'h75);
      // T4: bad parity, key word must hold, then 1B
      push_err();
      send_bits(8'h1C, 1'b1, 11);
      #(3*HALF);
      chk("t4_hold_after_err", {21'h0, ps2_key}, {21'h0, last_key});
      send_key(8'h1B);
      // T5: frame stalls after 5 data bits -> timeout, then glitch, then 29
      push_err();
      send_bits(8'h29, 1'b0, 6);
      #(250_000);
      chk("t5_queue_drained", exp_q.size(), 0);
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      #(5*HALF);
      send_key(8'h29);
      // T6: reset during parity of E0
      send_bits(8'hE0, 1'b0, 9);
      ps2_data = ~^8'hE0;
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF/2);
      reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_reset_key", {21'h0, ps2_key}, 32'h0);
      chk("t6_reset_valid", {31'h0, key_valid}, 32'h0);
      chk("t6_reset_err", {31'h0, frame_err}, 32'h0);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      m_tog = 1'b0; m_ext = 1'b0; m_rel = 1'b0; last_key = 11'h000;
      repeat (20) @(negedge clk);
      send_key(8'h1C);
      chk("t6_key_hold", {21'h0, ps2_key}, 32'h61C);

      repeat (500) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
